// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler: steps a 16-bit tuning word from start_ftw by step, holding each word
// for dwell+1 cycles. Define DDS_SWEEP_PINGPONG_EN to add a down-ramp back to start_ftw.
module dds_sweep_ctrl #(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        start,
  input  logic        abort,
  output logic [15:0] ftw_out,
  output logic        ftw_load,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StDwell, StDone} state_e;

  state_e             state_q, state_d;
  logic [15:0]        start_ftw_q, start_ftw_d;
  logic [15:0]        step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0]   steps_q, steps_d;
  logic [15:0]        ftw_q, ftw_d;
  logic               load_q, load_d;
  logic               wr_ok;
  logic [15:0]        ftw_next;
`ifdef DDS_SWEEP_PINGPONG_EN
  logic               dir_q, dir_d;
`endif

  // Register file; the *_d values already include a same-cycle write so start sees it.
  always_comb begin
    start_ftw_d = start_ftw_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    count_d     = count_q;
    wr_ok       = wr_en && (state_q != StDwell);
    if (wr_ok) begin
      case (wr_addr)
        3'd0:    start_ftw_d[7:0]  = wr_data;
        3'd1:    start_ftw_d[15:8] = wr_data;
        3'd2:    step_d[7:0]       = wr_data;
        3'd3:    step_d[15:8]      = wr_data;
        3'd4:    dwell_d           = wr_data[DWELL_W-1:0];
        3'd5:    count_d           = wr_data[CNT_W-1:0];
        default: ;
      endcase
    end
  end

`ifdef DDS_SWEEP_PINGPONG_EN
  assign ftw_next = dir_q ? (ftw_q - step_q) : (ftw_q + step_q);
`else
  assign ftw_next = ftw_q + step_q;
`endif

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    steps_d = steps_q;
    ftw_d   = ftw_q;
    load_d  = 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
    dir_d   = dir_q;
`endif
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = StDwell;
            ftw_d   = start_ftw_d;
            load_d  = 1'b1;
            dcnt_d  = dwell_d;
            steps_d = count_d;
`ifdef DDS_SWEEP_PINGPONG_EN
            dir_d   = 1'b0;
`endif
          end
        end
        StDwell: begin
          if (dcnt_q != '0) begin
            dcnt_d = dcnt_q - DWELL_W'(1);
          end else if (steps_q != '0) begin
            ftw_d   = ftw_next;
            load_d  = 1'b1;
            steps_d = steps_q - CNT_W'(1);
            dcnt_d  = dwell_q;
          end else begin
`ifdef DDS_SWEEP_PINGPONG_EN
            // End of up-ramp: the first down step happens right away, count-1 remain after it.
            if (!dir_q && (count_q != '0)) begin
              dir_d   = 1'b1;
              ftw_d   = ftw_q - step_q;
              load_d  = 1'b1;
              steps_d = count_q - CNT_W'(1);
              dcnt_d  = dwell_q;
            end else begin
              state_d = StDone;
            end
`else
            state_d = StDone;
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      start_ftw_q <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      count_q     <= '0;
      dcnt_q      <= '0;
      steps_q     <= '0;
      ftw_q       <= '0;
      load_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      start_ftw_q <= start_ftw_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      count_q     <= count_d;
      dcnt_q      <= dcnt_d;
      steps_q     <= steps_d;
      ftw_q       <= ftw_d;
      load_q      <= load_d;
      busy        <= (state_d == StDwell);
      done        <= (state_d == StDone);
`ifdef DDS_SWEEP_PINGPONG_EN
      dir_q       <= dir_d;
`endif
    end
  end

  assign ftw_out  = ftw_q;
  assign ftw_load = load_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed self-checking bench for dds_sweep_ctrl; cycle 1 is the cycle after start is sampled.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, wr_en, start, abort;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] ftw_out;
  logic        ftw_load, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic        tr_load [0:40];
  logic [15:0] tr_ftw  [0:40];
  logic        tr_busy [0:40];
  logic        tr_done [0:40];

  dds_sweep_ctrl #(.DWELL_W(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .abort    (abort),
    .ftw_out  (ftw_out),
    .ftw_load (ftw_load),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic program_regs(input logic [15:0] sf, input logic [15:0] st,
                              input logic [7:0] dw, input logic [7:0] cn);
    wr(3'd0, sf[7:0]);
    wr(3'd1, sf[15:8]);
    wr(3'd2, st[7:0]);
    wr(3'd3, st[15:8]);
    wr(3'd4, dw);
    wr(3'd5, cn);
  endtask

  // Pulse start, then record n cycles; optionally abort or poke writes+start mid-sweep.
  task automatic run(input int n, input int abort_cyc, input int poke_cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      tr_load[i] = ftw_load;
      tr_ftw[i]  = ftw_out;
      tr_busy[i] = busy;
      tr_done[i] = done;
      abort = (i == abort_cyc);
      wr_en = 1'b0;
      start = 1'b0;
      if (i == poke_cyc) begin
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hFF;
      end
      if (i == poke_cyc + 1) begin
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hFF; start = 1'b1;
      end
    end
    @(posedge clk);
    #1 abort = 1'b0; wr_en = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ftw_out !== 16'h0) begin n_fail++; $display("FAIL reset_ftw: got %h want 0000", ftw_out); end
    n_checks++; if (ftw_load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b want 0", ftw_load); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
  endtask

  // Shared by the basic sweep and the ignored-during-busy scenario: loads at 1,4,7,10, done at 13.
  task automatic check_basic_trace(input string tag);
    for (int i = 1; i <= 14; i++) begin
      logic el;
      el = ((i % 3) == 1) && (i <= 10);
      n_checks++;
      if (tr_load[i] !== el) begin
        n_fail++; $display("FAIL %s_load c%0d: got %b want %b", tag, i, tr_load[i], el);
      end
      if (el) begin
        n_checks++;
        if (tr_ftw[i] !== 16'h1000 + 16'(((i - 1) / 3) * 16'h0100)) begin
          n_fail++; $display("FAIL %s_ftw c%0d: got %h", tag, i, tr_ftw[i]);
        end
      end
    end
    n_checks++; if (tr_busy[12] !== 1'b1) begin n_fail++; $display("FAIL %s_busy12: got %b want 1", tag, tr_busy[12]); end
    n_checks++; if (tr_done[12] !== 1'b0) begin n_fail++; $display("FAIL %s_done12: got %b want 0", tag, tr_done[12]); end
    n_checks++; if (tr_done[13] !== 1'b1) begin n_fail++; $display("FAIL %s_done13: got %b want 1", tag, tr_done[13]); end
    n_checks++; if (tr_busy[13] !== 1'b0) begin n_fail++; $display("FAIL %s_busy13: got %b want 0", tag, tr_busy[13]); end
    n_checks++; if (tr_ftw[14] !== 16'h1300) begin n_fail++; $display("FAIL %s_hold: got %h want 1300", tag, tr_ftw[14]); end
  endtask

  task automatic test_basic;
    program_regs(16'h1000, 16'h0100, 8'd2, 8'd3);
    run(14, -1, -5);
    check_basic_trace("basic");
  endtask

  task automatic test_wrap;
    program_regs(16'hFF80, 16'h0100, 8'd0, 8'd1);
    run(5, -1, -5);
    for (int i = 1; i <= 5; i++) begin
      n_checks++;
      if (tr_load[i] !== (i <= 2)) begin
        n_fail++; $display("FAIL wrap_load c%0d: got %b", i, tr_load[i]);
      end
    end
    n_checks++; if (tr_ftw[1] !== 16'hFF80) begin n_fail++; $display("FAIL wrap_ftw1: got %h want ff80", tr_ftw[1]); end
    n_checks++; if (tr_ftw[2] !== 16'h0080) begin n_fail++; $display("FAIL wrap_ftw2: got %h want 0080", tr_ftw[2]); end
    n_checks++; if (tr_busy[2] !== 1'b1) begin n_fail++; $display("FAIL wrap_busy2: got %b want 1", tr_busy[2]); end
    n_checks++; if (tr_done[3] !== 1'b1) begin n_fail++; $display("FAIL wrap_done3: got %b want 1", tr_done[3]); end
    n_checks++; if (tr_ftw[5] !== 16'h0080) begin n_fail++; $display("FAIL wrap_hold: got %h want 0080", tr_ftw[5]); end
  endtask

  task automatic test_single;
    program_regs(16'h2222, 16'h0100, 8'd5, 8'd0);
    run(8, -1, -5);
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (tr_load[i] !== (i == 1)) begin
        n_fail++; $display("FAIL single_load c%0d: got %b", i, tr_load[i]);
      end
    end
    n_checks++; if (tr_ftw[1] !== 16'h2222) begin n_fail++; $display("FAIL single_ftw: got %h want 2222", tr_ftw[1]); end
    n_checks++; if (tr_done[6] !== 1'b0) begin n_fail++; $display("FAIL single_done6: got %b want 0", tr_done[6]); end
    n_checks++; if (tr_busy[6] !== 1'b1) begin n_fail++; $display("FAIL single_busy6: got %b want 1", tr_busy[6]); end
    n_checks++; if (tr_done[7] !== 1'b1) begin n_fail++; $display("FAIL single_done7: got %b want 1", tr_done[7]); end
  endtask

  task automatic test_abort;
    program_regs(16'h1000, 16'h0100, 8'd2, 8'd3);
    run(15, 5, -5);
    for (int i = 1; i <= 15; i++) begin
      n_checks++;
      if (tr_load[i] !== (i == 1 || i == 4)) begin
        n_fail++; $display("FAIL abort_load c%0d: got %b", i, tr_load[i]);
      end
    end
    n_checks++; if (tr_busy[5] !== 1'b1) begin n_fail++; $display("FAIL abort_busy5: got %b want 1", tr_busy[5]); end
    for (int i = 6; i <= 15; i += 3) begin
      n_checks++; if (tr_busy[i] !== 1'b0) begin n_fail++; $display("FAIL abort_busy c%0d: got %b want 0", i, tr_busy[i]); end
      n_checks++; if (tr_done[i] !== 1'b0) begin n_fail++; $display("FAIL abort_done c%0d: got %b want 0", i, tr_done[i]); end
      n_checks++; if (tr_ftw[i] !== 16'h1100) begin n_fail++; $display("FAIL abort_ftw c%0d: got %h want 1100", i, tr_ftw[i]); end
    end
  endtask

  task automatic test_write_with_start;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h34; start = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++; if (ftw_load !== 1'b1) begin n_fail++; $display("FAIL wrstart_load: got %b want 1", ftw_load); end
    n_checks++; if (ftw_out !== 16'h1034) begin n_fail++; $display("FAIL wrstart_ftw: got %h want 1034", ftw_out); end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrstart_abort_busy: got %b want 0", busy); end
  endtask

  task automatic test_busy_ignore;
    program_regs(16'h1000, 16'h0100, 8'd2, 8'd3);
    run(14, -1, 2);
    check_basic_trace("busyign");
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    n_checks++; if (ftw_load !== 1'b1) begin n_fail++; $display("FAIL rstmid_load: got %b want 1", ftw_load); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (ftw_out !== 16'h0) begin n_fail++; $display("FAIL rstmid_ftw: got %h want 0000", ftw_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++; if (ftw_load !== 1'b0) begin n_fail++; $display("FAIL rstmid_strobe c%0d: got %b want 0", i, ftw_load); end
    end
  endtask

`ifdef DDS_SWEEP_PINGPONG_EN
  task automatic test_pingpong;
    logic [15:0] exp_ftw [0:6];
    exp_ftw = '{16'h1000, 16'h1100, 16'h1200, 16'h1300, 16'h1200, 16'h1100, 16'h1000};
    program_regs(16'h1000, 16'h0100, 8'd2, 8'd3);
    run(23, -1, -5);
    for (int i = 1; i <= 23; i++) begin
      logic el;
      el = ((i % 3) == 1) && (i <= 19);
      n_checks++;
      if (tr_load[i] !== el) begin n_fail++; $display("FAIL pp_load c%0d: got %b want %b", i, tr_load[i], el); end
      if (el) begin
        n_checks++;
        if (tr_ftw[i] !== exp_ftw[(i - 1) / 3]) begin
          n_fail++; $display("FAIL pp_ftw c%0d: got %h want %h", i, tr_ftw[i], exp_ftw[(i - 1) / 3]);
        end
      end
    end
    n_checks++; if (tr_done[21] !== 1'b0) begin n_fail++; $display("FAIL pp_done21: got %b want 0", tr_done[21]); end
    n_checks++; if (tr_done[22] !== 1'b1) begin n_fail++; $display("FAIL pp_done22: got %b want 1", tr_done[22]); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef DDS_SWEEP_PINGPONG_EN
    test_pingpong();
`else
    test_basic();
    test_wrap();
    test_single();
`endif
    test_abort();
    test_write_with_start();
`ifndef DDS_SWEEP_PINGPONG_EN
    test_busy_ignore();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep scheduler for the DDS core. It holds a small register file written over a byte-wide bus, and on `start` steps the tuning word: start FTW, then start+step, start+2·step, and so on. Each tuning word is held for a programmable dwell time. It drives the phase accumulator's tuning-word input and load strobe, and sits between the top-level pin decode and the DDS datapath.

## Interface
Parameters:
- `DWELL_W`, 8: width of the dwell register. Must be ≤ 8.
- `CNT_W`, 8: width of the step-count register. Must be ≤ 8.

Ports:
- `clk`  in  1  — system clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `wr_en`  in  1  — register write strobe.
- `wr_addr`  in  3  — register address:
  - 0 = `start_ftw[7:0]`, 1 = `start_ftw[15:8]`
  - 2 = `step[7:0]`, 3 = `step[15:8]`
  - 4 = `dwell`, 5 = `count`
  - 6 and 7 are ignored.
- `wr_data`  in  8  — write data. Only the low `DWELL_W`/`CNT_W` bits are used for addresses 4 and 5.
- `start`  in  1  — begin sweep; single-cycle pulse or level.
- `abort`  in  1  — terminate sweep.
- `ftw_out`  out  16  — tuning word to the phase accumulator.
- `ftw_load`  out  1  — one-cycle strobe: `ftw_out` is new this cycle.
- `busy`  out  1  — sweep in progress.
- `done`  out  1  — last sweep completed.

## Operation
- States:
  - IDLE: reset state.
  - DWELL: holding the current FTW.
  - DONE: sweep completed.
- Register writes:
  - Accepted in IDLE and DONE.
  - Ignored while `busy`.
  - Registers reset to 0.
- `start` in IDLE or DONE:
  - `ftw_out` ← `start_ftw`, `ftw_load` = 1, `busy` = 1, `done` = 0.
  - Dwell counter ← `dwell`; steps_left ← `count`; direction ← up.
  - Enter DWELL.
- DWELL, dwell counter ≠ 0: decrement the counter.
- DWELL, dwell counter = 0:
  - If steps_left = 0, enter DONE.
  - Otherwise: `ftw_out` ← `ftw_out` + `step` (mod 2^16, wrap silently), `ftw_load` = 1, steps_left −1, dwell counter reloads.
- Dwell semantics: each FTW is held for `dwell`+1 cycles, so `dwell` = 0 means one cycle per word.
- `count` = N produces N+1 loads. N = 0 gives a single load of `start_ftw`.
- DONE:
  - `done` = 1, `busy` = 0, `ftw_out` holds the final word (the DDS keeps running at it).
  - Stays in DONE until `start` (restarts the sweep) or `abort` (goes to IDLE, `done` = 0).
- `start` while `busy` is ignored.
- `abort` in any state:
  - Next state IDLE; `busy` = 0, `done` = 0.
  - `ftw_out` holds its value; no `ftw_load`.
  - `abort` wins over simultaneous `start`.
- Register write coincident with `start` in IDLE: the write lands first and the sweep uses the new value.
- `rst` mid-sweep: immediate return to IDLE with reset values; no further strobes.

## Timing
- Reset values: `ftw_out` = 0, `ftw_load` = 0, `busy` = 0, `done` = 0; state IDLE.
- All outputs are registered. `start` sampled at edge 0 produces `ftw_out` = `start_ftw` and `ftw_load` = 1 in cycle 1.
- Load k (k = 0..N) occurs in cycle 1 + k·(D+1), where D = `dwell`.
- `done` rises and `busy` falls in cycle 1 + (N+1)·(D+1).
- `ftw_load` is never high on two consecutive cycles unless D = 0.
- A new `start` in DONE has the same 1-cycle latency.

## Configuration
- `DDS_SWEEP_PINGPONG_EN` defined:
  - After the up-ramp's final load, direction flips to down and steps_left reloads `count`.
  - Each step then subtracts `step`, ending exactly at `start_ftw`.
  - Total loads 2N+1; `done` in cycle 1 + (2N+1)·(D+1).
  - N = 0: a single load, no down phase.
- Not defined:
  - Up-ramp only; the direction state is absent.
  - Behaviour exactly as in Operation.

## Test plan
- Reset, then write `start_ftw` = 0x1000, `step` = 0x0100, `dwell` = 2, `count` = 3, then pulse `start`:
  - Loads 0x1000, 0x1100, 0x1200, 0x1300 in cycles 1, 4, 7, 10.
  - `done` = 1 and `busy` = 0 in cycle 13.
- `start_ftw` = 0xFF80, `step` = 0x0100, `count` = 1, `dwell` = 0:
  - Loads 0xFF80, then 0x0080 (wrap) in cycles 1 and 2.
  - `done` in cycle 3.
- `count` = 0, `dwell` = 5: a single load of `start_ftw` in cycle 1; `done` in cycle 7.
- Pulse `abort` in the cycle after the 2nd load of the first scenario:
  - IDLE next cycle; `ftw_out` stays 0x1100; no further `ftw_load`; `done` = 0.
- During a sweep, write `step` = 0xFFFF and pulse `start` again: both are ignored and the sequence matches the first scenario.
- With `DDS_SWEEP_PINGPONG_EN`, first-scenario settings:
  - Loads 0x1000, 0x1100, 0x1200, 0x1300, 0x1200, 0x1100, 0x1000 every 3 cycles.
  - `done` in cycle 22.
